// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, data and memory bus signals of the unified memory arbiter
// master is the arbiter's view, slave is the core/memory side.
interface unified_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_strb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_strb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        busy;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_strb, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_strb, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output busy
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_strb, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_strb, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - data-over-fetch arbiter for one shared single-port memory bus
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RSP_I, RSP_D} state_e;

  state_e      state_q;
  logic        m_req_q;
  logic        m_we_q;
  logic [3:0]  m_strb_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;

  logic        arb_now;
  logic        win_i;
  logic        win_d;
  logic        i_rvalid_w;
  logic        d_rvalid_w;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  // Re-arbitrating on the response cycle lets back-to-back transactions run without a bubble.
  assign arb_now = (state_q == IDLE) ||
                   (((state_q == RSP_I) || (state_q == RSP_D)) && bus.m_rvalid);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q;

  assign win_d = bus.d_req && !(bus.i_req && (starve_q == LIMIT));
  assign win_i = bus.i_req && !win_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (arb_now) begin
      if (!bus.i_req || win_i) begin
        starve_q <= '0;
      end else if (win_d && (starve_q != LIMIT)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  assign win_d = bus.d_req;
  assign win_i = bus.i_req && !bus.d_req;
`endif

  // Payload is captured at arbitration and held until m_gnt, so the selection cannot switch mid-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_strb_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      case (state_q)
        REQ_I, REQ_D: begin
          if (bus.m_gnt) begin
            state_q   <= (state_q == REQ_I) ? RSP_I : RSP_D;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_strb_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
          end
        end
        IDLE, RSP_I, RSP_D: begin
          if (arb_now) begin
            if (win_d) begin
              state_q   <= REQ_D;
              m_req_q   <= 1'b1;
              m_we_q    <= bus.d_we;
              m_strb_q  <= bus.d_strb;
              m_addr_q  <= bus.d_addr;
              m_wdata_q <= bus.d_wdata;
            end else if (win_i) begin
              state_q   <= REQ_I;
              m_req_q   <= 1'b1;
              m_we_q    <= 1'b0;
              m_strb_q  <= '0;
              m_addr_q  <= bus.i_addr;
              m_wdata_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          m_req_q   <= 1'b0;
          m_we_q    <= 1'b0;
          m_strb_q  <= '0;
          m_addr_q  <= '0;
          m_wdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_strb  = m_strb_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  // A response outside RSP_x decodes to neither port and is dropped.
  assign i_rvalid_w   = bus.m_rvalid && (state_q == RSP_I);
  assign d_rvalid_w   = bus.m_rvalid && (state_q == RSP_D);
  assign bus.i_gnt    = bus.m_gnt && (state_q == REQ_I);
  assign bus.d_gnt    = bus.m_gnt && (state_q == REQ_D);
  assign bus.i_rvalid = i_rvalid_w;
  assign bus.d_rvalid = d_rvalid_w;
  assign bus.i_rdata  = i_rvalid_w ? bus.m_rdata : '0;
  assign bus.d_rdata  = d_rvalid_w ? bus.m_rdata : '0;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
// Memory model returns (addr ^ KEY) for reads and 0 for writes.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  localparam logic [31:0] KEY = 32'hDEADBFEF;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_rsp[$];
  logic exp_gnt[$];

  bit   mem_en = 1'b0;
  int   gnt_delay = 0;
  int   rsp_delay = 0;
  int   mem_wcnt = 0;
  int   mem_pend = -1;
  logic [31:0] mem_pdata = '0;

  rsp_t mon_r;
  logic mon_g;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: grants after gnt_delay cycles of m_req, responds rsp_delay cycles after the cycle following m_gnt.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (mem_pend == 0) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mem_pdata;
          mem_pend     = -1;
        end else begin
          bus.m_rvalid = 1'b0;
          bus.m_rdata  = '0;
          if (mem_pend > 0) mem_pend--;
        end
        if (bus.m_req && (mem_wcnt >= gnt_delay)) begin
          bus.m_gnt = 1'b1;
          mem_wcnt  = 0;
          mem_pend  = rsp_delay;
          mem_pdata = bus.m_we ? 32'h0 : (bus.m_addr ^ KEY);
        end else begin
          bus.m_gnt = 1'b0;
          mem_wcnt  = bus.m_req ? mem_wcnt + 1 : 0;
        end
      end
    end
  end

  // Monitor: pops expected grants and responses whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.i_gnt || bus.d_gnt) begin
          if (exp_gnt.size() == 0) begin
            check("unexpected_gnt", 128'({bus.i_gnt, bus.d_gnt}), 128'(2'b00));
          end else begin
            mon_g = exp_gnt.pop_front();
            check("gnt_port", 128'({bus.i_gnt, bus.d_gnt}), 128'(mon_g ? 2'b01 : 2'b10));
          end
        end
        if (bus.i_rvalid || bus.d_rvalid) begin
          if (exp_rsp.size() == 0) begin
            check("unexpected_rvalid", 128'({bus.i_rvalid, bus.d_rvalid}), 128'(2'b00));
          end else begin
            mon_r = exp_rsp.pop_front();
            check("rsp", 128'({bus.i_rvalid, bus.d_rvalid, bus.d_rvalid ? bus.d_rdata : bus.i_rdata}),
                  128'({~mon_r.is_d, mon_r.is_d, mon_r.data}));
          end
        end
        if (!bus.i_rvalid) check("i_rdata_zero", 128'(bus.i_rdata), 128'(0));
        if (!bus.d_rvalid) check("d_rdata_zero", 128'(bus.d_rdata), 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input bit is_d, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? bus.d_gnt : bus.i_gnt;
    end
    check(name, 128'(seen), 128'(1));
    tick();
    if (is_d) bus.d_req = 1'b0;
    else      bus.i_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 50 && (exp_rsp.size() + exp_gnt.size()) > 0; n++) @(negedge clk);
    @(negedge clk);
    check(name, 128'(exp_rsp.size() + exp_gnt.size()), 128'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 128'({bus.m_req, bus.m_we, bus.m_strb, bus.i_gnt, bus.d_gnt,
                               bus.i_rvalid, bus.d_rvalid, bus.busy}), 128'(0));
    check({tag, "_addr"}, 128'({bus.m_addr, bus.m_wdata}), 128'(0));
    check({tag, "_rdata"}, 128'({bus.i_rdata, bus.d_rdata}), 128'(0));
  endtask

  initial begin
    int nd;
    int ni;
    int exp_ni;
    int nreq;
    bit done;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_strb = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    tick();
    rst_n  = 1'b1;
    mem_en = 1'b1;
    tick();

    // Single fetch, zero wait states.
    exp_gnt.push_back(1'b0);
    exp_rsp.push_back('{1'b0, 32'hDEADBEEF});
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("t1_m_req_addr", 128'({bus.m_req, bus.m_we, bus.m_addr}), 128'({1'b1, 1'b0, 32'h100}));
    check("t1_i_gnt", 128'(bus.i_gnt), 128'(1));
    tick();
    bus.i_req = 1'b0;
    @(negedge clk);
    check("t1_i_rvalid", 128'({bus.i_rvalid, bus.i_rdata}), 128'({1'b1, 32'hDEADBEEF}));
    tick();
    @(negedge clk);
    check("t1_idle", 128'({bus.busy, bus.m_req}), 128'(0));

    // Data write with grant delayed three cycles.
    gnt_delay = 3;
    tick();
    exp_gnt.push_back(1'b1);
    exp_rsp.push_back('{1'b1, 32'h0});
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_strb = 4'hF;
    bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    nreq = 0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.m_req) begin
        nreq++;
        check("t2_payload", 128'({bus.m_we, bus.m_strb, bus.m_addr, bus.m_wdata}),
              128'({1'b1, 4'hF, 32'h200, 32'h12345678}));
      end
      done = bus.d_gnt;
    end
    check("t2_req_cycles", 128'(nreq), 128'(4));
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_strb = '0; bus.d_wdata = '0;
    @(negedge clk);
    check("t2_payload_cleared", 128'({bus.m_req, bus.m_we, bus.m_strb, bus.m_addr, bus.m_wdata}), 128'(0));
    drain("t2_drain");
    gnt_delay = 0;

    // Continuous contention for ten transactions.
    exp_ni = 0;
    for (int i = 0; i < 10; i++) begin
      logic is_d;
`ifdef ARB_STARVE_GUARD_EN
      is_d = ((i % 5) != 4);
`else
      is_d = 1'b1;
`endif
      if (!is_d) exp_ni++;
      exp_gnt.push_back(is_d);
      exp_rsp.push_back('{is_d, is_d ? 32'hDEADBCEF : 32'hDEADBBEF});
    end
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_addr = 32'h300;
    nd = 0;
    ni = 0;
    for (int n = 0; n < 200 && (nd + ni) < 10; n++) begin
      @(negedge clk);
      if (bus.d_gnt) nd++;
      if (bus.i_gnt) ni++;
    end
    check("t3_grants", 128'(nd + ni), 128'(10));
    check("t3_i_gnt_count", 128'(ni), 128'(exp_ni));
    tick();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    drain("t3_drain");

    // Spurious m_rvalid in IDLE and in REQ_D.
    mem_en = 1'b0;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h55;
    @(negedge clk);
    check("t4_idle_rvalid", 128'({bus.i_rvalid, bus.d_rvalid, bus.busy}), 128'(0));
    tick();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    exp_gnt.push_back(1'b1);
    exp_rsp.push_back('{1'b1, 32'hDEADB8EF});
    bus.d_req = 1'b1; bus.d_addr = 32'h700;
    @(negedge clk);
    check("t4_idle_state", 128'({bus.busy, bus.m_req}), 128'(0));
    tick();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h66;
    @(negedge clk);
    check("t4_req_rvalid", 128'({bus.i_rvalid, bus.d_rvalid}), 128'(0));
    tick();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    @(negedge clk);
    check("t4_req_hold", 128'({bus.busy, bus.m_req, bus.m_addr}), 128'({2'b11, 32'h700}));
    tick();
    mem_en = 1'b1;
    wait_gnt(1'b1, "t4_gnt_seen");
    drain("t4_drain");

    // Reset during RSP_D; the late response must be dropped.
    rsp_delay = 2;
    tick();
    exp_gnt.push_back(1'b1);
    bus.d_req = 1'b1; bus.d_addr = 32'h500;
    wait_gnt(1'b1, "t5_gnt_seen");
    #1;
    check("t5_busy_before", 128'(bus.busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_late_rvalid", 128'({bus.i_rvalid, bus.d_rvalid, bus.busy, bus.m_rvalid}), 128'(4'b0001));
    rsp_delay = 0;
    tick();
    exp_gnt.push_back(1'b1);
    exp_rsp.push_back('{1'b1, 32'hDEADB9EF});
    bus.d_req = 1'b1; bus.d_addr = 32'h600;
    wait_gnt(1'b1, "t5_next_gnt");
    drain("t5_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported memory bus between the core's instruction-fetch port and data-memory port for configurations with a unified instruction/data memory. It sits between the fetch/memory stages and the external memory. It arbitrates with fixed data-over-instruction priority and an optional starvation guard. It sequences each transaction as request, grant, then response, with one transaction outstanding at a time.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data wins allowed while i_req is pending before fetch is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  32  fetch address.
- i_gnt  out  1  fetch request accepted by memory this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with payload until d_gnt.
- d_we  in  1  data write enable.
- d_strb  in  4  byte strobes.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response (read data or write ack).
- d_rdata  out  32  data read data.
- m_req  out  1  bus request.
- m_we, m_strb, m_addr, m_wdata  out  1/4/32/32  bus payload.
- m_gnt  in  1  memory accepts the request.
- m_rvalid  in  1  memory response; exactly one per accepted request, reads and writes alike.
- m_rdata  in  32  memory read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ_I, REQ_D, RSP_I, RSP_D.
- Arbitration happens in IDLE, and in RSP_x in the cycle m_rvalid=1:
  - d_req only: go to REQ_D.
  - i_req only: go to REQ_I.
  - Both asserted: REQ_D, unless the starvation guard fires (see Configuration).
  - Neither: IDLE.
- REQ_x:
  - m_req=1 and the payload is muxed from port x.
  - A fetch drives m_we=0, m_strb=0, m_wdata=0.
  - The selection is locked until m_gnt; it is never switched mid-request.
  - On m_gnt: x_gnt=1 and the FSM goes to RSP_x.
- RSP_x:
  - m_req=0.
  - On m_rvalid: x_rvalid=1 and x_rdata=m_rdata, then re-arbitrate.
- Payload outputs are 0 in all non-REQ states.
- x_rdata is 0 whenever x_rvalid=0.
- m_rvalid outside RSP_x is ignored and routed nowhere.
- A port may raise a new req after its gnt. That request is not accepted before its previous response has been returned.
- A req dropped before gnt is a protocol violation; behaviour in that case is unspecified.
- Reset asserted mid-transaction: the FSM returns to IDLE and any pending response is discarded.

## Timing
- Reset values: m_req, m_we=0; m_strb, m_addr, m_wdata=0; i_gnt, d_gnt, i_rvalid, d_rvalid=0; i_rdata, d_rdata=0; busy=0; state IDLE; starve counter 0.
- Path types:
  - The state register is sequential.
  - x_gnt = m_gnt & (state==REQ_x), combinational.
  - x_rvalid = m_rvalid & (state==RSP_x), combinational.
- Latency:
  - A req sampled in cycle N gives m_req in cycle N+1.
  - With m_gnt in N+1 and m_rvalid in N+2, the response is at N+2.
  - The next request goes out at N+3.
- Peak throughput is one transaction per 2 cycles.
- Arbitration on the m_rvalid cycle uses the req values of that same cycle. No idle bubble is inserted.

## Configuration
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments, saturating at STARVE_LIMIT, on each data win while i_req=1.
  - It clears on any fetch win, and on any arbitration where i_req=0.
  - When the count equals STARVE_LIMIT and both ports request, fetch wins.
- Undefined:
  - The counter is absent and data priority is strict.
  - Continuous d_req starves fetch indefinitely.

## Test plan
- Single fetch, memory with 0 wait states: i_req=1, i_addr=0x100, m_rdata=0xDEADBEEF.
  - Required: m_req=1 with m_addr=0x100 in cycle 1.
  - Required: i_gnt in cycle 1.
  - Required: i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 2.
- Data write with m_gnt delayed 3 cycles: d_we=1, d_strb=0xF, d_addr=0x200, d_wdata=0x12345678.
  - Required: the payload is held stable for 4 cycles.
  - Required: d_gnt fires once.
  - Required: one d_rvalid, with d_rdata=0.
- Simultaneous i_req and d_req, guard undefined: both requests continuous for 10 transactions.
  - Required: all 10 are granted to data.
  - Required: i_gnt never asserts.
- Same stimulus with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4.
  - Required grant order: D, D, D, D, I, D, D, D, D, I.
- Spurious m_rvalid in IDLE and in REQ_D.
  - Required: no x_rvalid asserts.
  - Required: the FSM state is unchanged.
- rst_n pulled low during RSP_D.
  - Required: all outputs return to 0 asynchronously.
  - Required: the late m_rvalid after reset is ignored.
  - Required: the next d_req completes normally.
